// File: rtl/reg_transfer_seq.sv
// rtl/reg_transfer_seq.sv - register-to-register transfer sequencer (optional SEQ_LED_EN status outputs)
module reg_transfer_seq #(
    parameter int NREG     = 8,
    parameter int N        = 8,
    parameter int SEL_CYC  = 2,
    parameter int LD_CYC   = 1,
    parameter int HOLD_CYC = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [$clog2(NREG)-1:0] src,
    input  logic [$clog2(NREG)-1:0] dst,
    input  logic [N-1:0]            data_bus_in,
    output logic [NREG-1:0]         sel,
    output logic [NREG-1:0]         ld,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [N-1:0]            captured
`ifdef SEQ_LED_EN
    ,
    output logic [2*$clog2(NREG)-1:0] led_last,
    output logic                      led_busy
`endif
);

    localparam int IW   = $clog2(NREG);
    localparam int MAXC = (SEL_CYC > LD_CYC) ? ((SEL_CYC > HOLD_CYC) ? SEL_CYC : HOLD_CYC)
                                             : ((LD_CYC > HOLD_CYC) ? LD_CYC : HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    // Last count value of each timed phase; the counter restarts at 0 on every state entry.
    localparam logic [CW-1:0] SEL_LAST  = CW'(SEL_CYC - 1);
    localparam logic [CW-1:0] LD_LAST   = CW'(LD_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_LOAD,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   src_q, src_d;
    logic [IW-1:0]   dst_q, dst_d;
    logic [NREG-1:0] sel_q, sel_d;
    logic [NREG-1:0] ld_q, ld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [N-1:0]    cap_q, cap_d;
    logic [2*IW-1:0] led_q, led_d;
    logic            req_ok;

    function automatic logic [NREG-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign req_ok = (src != dst) && (int'(src) < NREG) && (int'(dst) < NREG);

    // Phase sequencing; strobes are decoded from the next state so every output is a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = 1'b0;
        cap_d   = cap_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_ok) begin
                        src_d   = src;
                        dst_d   = dst;
                        state_d = S_SELECT;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SELECT: begin
                if (cnt_q == SEL_LAST) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                if (cnt_q == LD_LAST) begin
                    cap_d   = data_bus_in;
                    state_d = (HOLD_CYC == 0) ? S_DONE : S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        sel_d  = (state_d == S_SELECT || state_d == S_LOAD || state_d == S_HOLD) ? onehot(src_d) : '0;
        ld_d   = (state_d == S_LOAD) ? onehot(dst_d) : '0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        led_d  = (state_d == S_DONE) ? {dst_d, src_d} : led_q;
    end

    // State, counter, latched request and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            sel_q   <= '0;
            ld_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cap_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            sel_q   <= sel_d;
            ld_q    <= ld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
            led_q   <= led_d;
        end
    end

    assign sel      = sel_q;
    assign ld       = ld_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign captured = cap_q;

`ifdef SEQ_LED_EN
    assign led_last = led_q;
    assign led_busy = busy_q;
`else
    logic unused_led;
    assign unused_led = ^led_q;
`endif

endmodule

// File: tb/tb_reg_transfer_seq.sv
// tb/tb_reg_transfer_seq.sv - self-checking bench for reg_transfer_seq (default and SEL1/LD3/HOLD0 builds)
module tb_reg_transfer_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] src   = '0;
    logic [2:0] dst   = '0;
    logic [7:0] data  = '0;

    logic [7:0] sel_w [2];
    logic [7:0] ld_w  [2];
    logic [7:0] cap_w [2];
    logic       busy_w[2];
    logic       done_w[2];
    logic       err_w [2];
`ifdef SEQ_LED_EN
    logic [5:0] led_w [2];
    logic       ledb_w[2];
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    reg_transfer_seq u0 (
        .clock(clock), .reset(reset), .start(start), .src(src), .dst(dst),
        .data_bus_in(data), .sel(sel_w[0]), .ld(ld_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .err(err_w[0]), .captured(cap_w[0])
`ifdef SEQ_LED_EN
        , .led_last(led_w[0]), .led_busy(ledb_w[0])
`endif
    );

    reg_transfer_seq #(.SEL_CYC(1), .LD_CYC(3), .HOLD_CYC(0)) u1 (
        .clock(clock), .reset(reset), .start(start), .src(src), .dst(dst),
        .data_bus_in(data), .sel(sel_w[1]), .ld(ld_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .err(err_w[1]), .captured(cap_w[1])
`ifdef SEQ_LED_EN
        , .led_last(led_w[1]), .led_busy(ledb_w[1])
`endif
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a transfer is a timeline t=1..S+L+H+1 after acceptance.
    int         PS[2] = '{2, 1};
    int         PL[2] = '{1, 3};
    int         PH[2] = '{1, 0};
    int         mt[2] = '{0, 0};
    logic [2:0] ms[2] = '{3'd0, 3'd0};
    logic [2:0] md[2] = '{3'd0, 3'd0};
    logic [7:0] mcap[2] = '{8'd0, 8'd0};
    logic       merr[2] = '{1'b0, 1'b0};
    logic [5:0] mled[2] = '{6'd0, 6'd0};

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            int last;
            last = PS[i] + PL[i] + PH[i] + 1;
            if (reset) begin
                mt[i] = 0; mcap[i] = '0; merr[i] = 1'b0; mled[i] = '0;
            end else if (mt[i] == 0) begin
                merr[i] = 1'b0;
                if (start) begin
                    if (src != dst) begin
                        mt[i] = 1; ms[i] = src; md[i] = dst;
                    end else begin
                        merr[i] = 1'b1;
                    end
                end
            end else begin
                merr[i] = 1'b0;
                if (mt[i] == PS[i] + PL[i]) mcap[i] = data;
                if (mt[i] == last) mt[i] = 0;
                else begin
                    mt[i]++;
                    if (mt[i] == last) mled[i] = {md[i], ms[i]};
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            int t;
            logic [7:0] es, el;
            t  = mt[i];
            es = (t >= 1 && t <= PS[i] + PL[i] + PH[i]) ? (8'd1 << ms[i]) : 8'd0;
            el = (t > PS[i] && t <= PS[i] + PL[i]) ? (8'd1 << md[i]) : 8'd0;
            chk($sformatf("model dut%0d sel,ld,busy,done,err,cap", i),
                {sel_w[i], ld_w[i], busy_w[i], done_w[i], err_w[i], cap_w[i]},
                {es, el, (t != 0), (t == PS[i] + PL[i] + PH[i] + 1), merr[i], mcap[i]});
`ifdef SEQ_LED_EN
            chk($sformatf("model dut%0d led_last,led_busy", i), {led_w[i], ledb_w[i]}, {mled[i], busy_w[i]});
`endif
        end
    end

    typedef struct {
        logic       st;
        logic [2:0] s;
        logic [2:0] d;
        logic [7:0] dat;
        logic [7:0] esel;
        logic [7:0] eld;
        logic       ebusy;
        logic       edone;
        logic       eerr;
        logic [7:0] ecap;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 3'd0, 3'd1, 8'h5A, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 3'd0, 3'd1, 8'h5A, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 3'd0, 3'd1, 8'h5A, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 3'd0, 3'd1, 8'h5A, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[4]  = '{1'b0, 3'd0, 3'd1, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A};
        tbl[5]  = '{1'b0, 3'd0, 3'd1, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A};
        tbl[6]  = '{1'b1, 3'd3, 3'd3, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
        tbl[7]  = '{1'b0, 3'd3, 3'd3, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A};
        tbl[8]  = '{1'b1, 3'd2, 3'd6, 8'h33, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[9]  = '{1'b1, 3'd4, 3'd5, 8'h33, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[10] = '{1'b0, 3'd4, 3'd5, 8'h33, 8'h04, 8'h40, 1'b1, 1'b0, 1'b0, 8'h5A};
        tbl[11] = '{1'b0, 3'd4, 3'd5, 8'h33, 8'h04, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33};
        tbl[12] = '{1'b1, 3'd0, 3'd1, 8'h33, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h33};
        tbl[13] = '{1'b0, 3'd0, 3'd1, 8'h33, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33};

        // Reset state
        repeat (2) @(negedge clock);
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset dut%0d", i),
                {sel_w[i], ld_w[i], busy_w[i], done_w[i], err_w[i], cap_w[i]}, 64'd0);
        reset = 1'b0;

        // Directed table on the default build
        for (int r = 0; r < 14; r++) begin
            start = tbl[r].st; src = tbl[r].s; dst = tbl[r].d; data = tbl[r].dat;
            @(posedge clock);
            @(negedge clock);
            chk($sformatf("tbl[%0d]", r),
                {sel_w[0], ld_w[0], busy_w[0], done_w[0], err_w[0], cap_w[0]},
                {tbl[r].esel, tbl[r].eld, tbl[r].ebusy, tbl[r].edone, tbl[r].eerr, tbl[r].ecap});
        end
        start = 1'b0;

        // Asynchronous reset during LOAD
        start = 1'b1; src = 3'd2; dst = 3'd6; data = 8'h44;
        @(posedge clock);
        @(negedge clock) start = 1'b0;
        repeat (2) @(posedge clock);
        #1 chk("pre-reset ld", ld_w[0], 8'h40);
        #1 reset = 1'b1;
        #1 chk("async reset outputs", {sel_w[0], ld_w[0], busy_w[0], cap_w[0]}, 64'd0);
        @(negedge clock) reset = 1'b0;
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        repeat (5) @(negedge clock);
        chk("post-reset transfer cap,busy", {cap_w[0], busy_w[0]}, {8'h44, 1'b0});

        // SEL=1 LD=3 HOLD=0 build, bus value changes in the last LOAD cycle
        start = 1'b1; src = 3'd7; dst = 3'd0; data = 8'h11;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock);
            @(negedge clock);
            start = 1'b0;
            chk($sformatf("alt cycle%0d sel,ld,done", c), {sel_w[1], ld_w[1], done_w[1]},
                {(c <= 4) ? 8'h80 : 8'h00, (c >= 2 && c <= 4) ? 8'h01 : 8'h00, (c == 5)});
            if (c == 4) data = 8'h22;
        end
        chk("alt captured,busy", {cap_w[1], busy_w[1]}, {8'h22, 1'b0});

`ifdef SEQ_LED_EN
        start = 1'b1; src = 3'd1; dst = 3'd2;
        @(negedge clock) start = 1'b0;
        repeat (4) @(negedge clock);
        chk("led_last at done", {done_w[0], led_w[0]}, {1'b1, 3'd2, 3'd1});
        @(negedge clock);
        chk("led_last after done", led_w[0], {3'd2, 3'd1});
`endif

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 2) == 0);
            src   = 3'($urandom_range(0, 7));
            dst   = ($urandom_range(0, 3) == 0) ? src : 3'($urandom_range(0, 7));
            data  = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
